// File: rtl/capture_fifo_writer.sv
// Camera pixel capture: tags each pixel with its {bank, index} SRAM address and queues it in a FIFO.
// An issue FSM drains the FIFO to the SRAM controller over a start/ready handshake; overruns are dropped and counted.
module capture_fifo_writer #(
  parameter int PIX_W        = 12,
  parameter int DATA_W       = 16,
  parameter int IDX_W        = 15,
  parameter int BANK_W       = 2,
  parameter int FRAME_PIXELS = 19200,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          frame_start,
  input  logic [BANK_W-1:0]             bank_sel,
  input  logic                          pix_valid,
  input  logic [PIX_W-1:0]              pix_data,
  input  logic                          sram_ready,
  output logic                          sram_start,
  output logic                          sram_rw,
  output logic [BANK_W+IDX_W-1:0]       addr_out,
  output logic [DATA_W-1:0]             data_out,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [15:0]                   drop_count,
  input  logic                          clear_ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 1 + BANK_W + IDX_W + PIX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_PIXELS - 1);

  // Handshake: sram_start is low for exactly one cycle per word; the controller then drops
  // sram_ready while busy and raises it again when the write is complete.
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state, state_next;
  logic   start_next, done_next;

  logic                  active;
  logic [IDX_W-1:0]      idx;
  logic [BANK_W-1:0]     bank;
  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  full, empty;
  logic                  active_eff, is_last, push, drop, pop;
  logic [IDX_W-1:0]      idx_eff;
  logic [BANK_W-1:0]     bank_eff;
  logic [ENT_W-1:0]      head;
  logic                  last_q;

  // A frame_start takes effect in its own cycle, so a coincident pixel becomes pixel 0 of the new frame.
  assign active_eff = frame_start | active;
  assign idx_eff    = frame_start ? '0 : idx;
  assign bank_eff   = frame_start ? bank_sel : bank;
  assign is_last    = (idx_eff == LAST_IDX);
  assign full       = (count == CNT_W'(FIFO_DEPTH));
  assign empty      = (count == '0);
  assign push       = pix_valid & active_eff & ~full;
  assign drop       = pix_valid & ~push;
  assign pop        = (state == IDLE) & ~empty;
  assign head       = mem[rd_ptr];
  assign sram_rw    = 1'b0;
  assign fifo_level = count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
      idx    <= '0;
      bank   <= '0;
    end else begin
      if (frame_start) bank <= bank_sel;
      if (push) begin
        active <= ~is_last;
        idx    <= is_last ? '0 : idx_eff + IDX_W'(1);
      end else if (frame_start) begin
        active <= 1'b1;
        idx    <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {is_last, bank_eff, idx_eff, pix_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // A drop in the same cycle as clear_ovf wins, leaving a count of one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end else if (drop) begin
      overflow   <= 1'b1;
      drop_count <= clear_ovf ? 16'd1 : ((drop_count == 16'hFFFF) ? drop_count : drop_count + 16'd1);
    end else if (clear_ovf) begin
      overflow   <= 1'b0;
      drop_count <= '0;
    end
  end

  always_comb begin
    state_next = state;
    start_next = 1'b1;
    done_next  = 1'b0;
    case (state)
      IDLE:      if (!empty) state_next = ISSUE;
      ISSUE:     state_next = WAIT_BUSY;
      WAIT_BUSY: if (!sram_ready) state_next = WAIT_DONE;
      WAIT_DONE: if (sram_ready) begin
                   state_next = IDLE;
                   done_next  = last_q;
                 end
      default:   state_next = IDLE;
    endcase
    if (state_next == ISSUE) start_next = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      sram_start <= 1'b1;
      frame_done <= 1'b0;
      addr_out   <= '0;
      data_out   <= '0;
      last_q     <= 1'b0;
    end else begin
      state      <= state_next;
      sram_start <= start_next;
      frame_done <= done_next;
      if (pop) begin
        addr_out <= head[ENT_W-2 -: BANK_W+IDX_W];
        data_out <= DATA_W'(head[PIX_W-1:0]);
        last_q   <= head[ENT_W-1];
      end
    end
  end
endmodule

// File: tb/tb_capture_fifo_writer.sv
// Bench for capture_fifo_writer (FRAME_PIXELS=12): directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_capture_fifo_writer;
  localparam int FP    = 12;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start, pix_valid, sram_ready, clear_ovf;
  logic [1:0]  bank_sel;
  logic [11:0] pix_data;
  logic        sram_start, sram_rw, frame_done, overflow;
  logic [16:0] addr_out;
  logic [15:0] data_out, drop_count;
  logic [3:0]  fifo_level;

  capture_fifo_writer #(.FRAME_PIXELS(FP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .bank_sel(bank_sel),
    .pix_valid(pix_valid), .pix_data(pix_data), .sram_ready(sram_ready),
    .sram_start(sram_start), .sram_rw(sram_rw), .addr_out(addr_out), .data_out(data_out),
    .frame_done(frame_done), .overflow(overflow), .drop_count(drop_count),
    .clear_ovf(clear_ovf), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // SRAM controller: goes busy for busy_cycles after each start, or stays busy while hold_low.
  int busy_cycles = 2;
  bit hold_low    = 1'b0;
  int busy_left   = 0;
  initial begin : responder
    sram_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!reset) busy_left = 0;
      else if (!sram_start) busy_left = busy_cycles;
      sram_ready = !(hold_low || busy_left > 0);
      if (busy_left > 0) busy_left--;
    end
  end

  logic [32:0] got_q[$];
  int n_starts = 0, fd_count = 0, starts_at_fd = 0;
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (reset) begin
        if (!sram_start) begin
          got_q.push_back({addr_out, data_out});
          n_starts++;
        end
        if (frame_done) begin
          fd_count++;
          starts_at_fd = n_starts;
        end
      end
    end
  end

  // Reference model: FIFO as an occupancy count, controller as a fixed per-word service time.
  logic [32:0] exp_q[$];
  bit model_on = 1'b0;
  bit m_active, m_ovf;
  int m_idx, m_bank, m_count, m_wait, m_dc, m_busy, exp_fd;

  task automatic model_reset();
    m_active = 0; m_ovf = 0; m_idx = 0; m_bank = 0; m_count = 0; m_wait = 0; m_dc = 0;
    exp_fd = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input bit fs, input logic [1:0] bs, input bit pv,
                            input logic [11:0] px, input bit clr);
    bit full_now, act, psh, pp;
    int ix, bk;
    full_now = (m_count == DEPTH);
    act = fs || m_active;
    ix  = fs ? 0 : m_idx;
    bk  = fs ? int'(bs) : m_bank;
    psh = pv && act && !full_now;
    if (m_wait > 0) m_wait--;
    pp = (m_wait == 0) && (m_count > 0);
    if (pp) m_wait = m_busy + 2;
    if (fs) begin m_active = 1; m_idx = 0; m_bank = int'(bs); end
    if (psh) begin
      exp_q.push_back({17'(bk * 32768 + ix), 16'(px)});
      if (ix == FP - 1) begin m_active = 0; m_idx = 0; exp_fd++; end
      else m_idx = ix + 1;
    end
    if (pv && !psh) begin
      m_ovf = 1;
      m_dc  = clr ? 1 : ((m_dc == 65535) ? 65535 : m_dc + 1);
    end else if (clr) begin
      m_ovf = 0; m_dc = 0;
    end
    m_count = m_count + int'(psh) - int'(pp);
  endtask

  task automatic drive(input bit fs, input logic [1:0] bs, input bit pv,
                       input logic [11:0] px, input bit clr);
    frame_start = fs; bank_sel = bs; pix_valid = pv; pix_data = px; clear_ovf = clr;
    if (model_on) model_step(fs, bs, pv, px, clr);
    @(negedge clk);
    if (model_on) begin
      check("rnd_level", 32'(fifo_level), 32'(m_count));
      check("rnd_overflow", 32'(overflow), 32'(m_ovf));
      check("rnd_drop_count", 32'(drop_count), 32'(m_dc));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, 12'd0, 1'b0);
  endtask

  task automatic wait_starts(input int n, input int budget, input string name);
    int k;
    k = 0;
    while (n_starts < n && k < budget) begin idle(1); k++; end
    check({name, "_timeout"}, 32'(n_starts >= n), 32'd1);
  endtask

  task automatic do_reset();
    frame_start = 0; bank_sel = 0; pix_valid = 0; pix_data = 0; clear_ovf = 0; hold_low = 0;
    model_on = 0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    got_q.delete(); n_starts = 0; fd_count = 0; starts_at_fd = 0;
    model_reset();
  endtask

  function automatic logic [32:0] got_at(input int i);
    return (got_q.size() > i) ? got_q[i] : '1;
  endfunction

  typedef struct {
    bit          fs;
    logic [1:0]  bank;
    logic [11:0] pix;
    logic [16:0] exp_addr;
    logic [15:0] exp_data;
  } vec_t;
  vec_t tbl[7];

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    tbl[0] = '{1'b1, 2'd2, 12'h001, 17'h10000, 16'h0001};
    tbl[1] = '{1'b0, 2'd0, 12'h002, 17'h10001, 16'h0002};
    tbl[2] = '{1'b0, 2'd0, 12'h003, 17'h10002, 16'h0003};
    tbl[3] = '{1'b1, 2'd1, 12'hABC, 17'h08000, 16'h0ABC};
    tbl[4] = '{1'b0, 2'd3, 12'hFFF, 17'h08001, 16'h0FFF};
    tbl[5] = '{1'b1, 2'd3, 12'h800, 17'h18000, 16'h0800};
    tbl[6] = '{1'b1, 2'd0, 12'h07F, 17'h00000, 16'h007F};

    reset = 1'b0; frame_start = 0; bank_sel = 0; pix_valid = 0; pix_data = 0; clear_ovf = 0;
    #12;
    check("rst_sram_start", 32'(sram_start), 32'd1);
    check("rst_sram_rw", 32'(sram_rw), 32'd0);
    check("rst_addr", 32'(addr_out), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);

    // Vector table: one pixel per record, each written before the next is applied.
    do_reset();
    busy_cycles = 2;
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i].fs, tbl[i].bank, 1'b1, tbl[i].pix, 1'b0);
      wait_starts(i + 1, 20, "vec");
      idle(5);
      check("vec_addr", 32'(got_at(i) >> 16), 32'(tbl[i].exp_addr));
      check("vec_data", 32'(got_at(i) & 33'hFFFF), 32'(tbl[i].exp_data));
    end
    check("vec_frame_done", 32'(fd_count), 32'd0);

    // Full frame plus one extra pixel, spaced so the FIFO never fills.
    do_reset();
    drive(1'b1, 2'd0, 1'b1, 12'h200, 1'b0);
    for (int i = 1; i <= FP; i++) begin
      idle(4);
      drive(1'b0, 2'd0, 1'b1, 12'(12'h200 + i), 1'b0);
    end
    idle(30);
    check("frm_writes", 32'(n_starts), 32'(FP));
    check("frm_done_count", 32'(fd_count), 32'd1);
    check("frm_done_after_last", 32'(starts_at_fd), 32'(FP));
    check("frm_overflow", 32'(overflow), 32'd1);
    check("frm_drop_count", 32'(drop_count), 32'd1);
    check("frm_last_word", 32'(got_at(FP - 1)), 32'({17'(FP - 1), 16'(12'h200 + FP - 1)}));

    // Controller stalled: 12 back-to-back pixels against 1 in flight + 8 queued.
    do_reset();
    hold_low = 1'b1;
    drive(1'b1, 2'd0, 1'b1, 12'h100, 1'b0);
    for (int i = 1; i < 12; i++) drive(1'b0, 2'd0, 1'b1, 12'(12'h100 + i), 1'b0);
    idle(2);
    check("stall_starts", 32'(n_starts), 32'd1);
    check("stall_level", 32'(fifo_level), 32'd8);
    check("stall_drop_count", 32'(drop_count), 32'd3);
    check("stall_overflow", 32'(overflow), 32'd1);
    hold_low = 1'b0;
    wait_starts(9, 100, "stall");
    idle(20);
    check("stall_total_writes", 32'(n_starts), 32'd9);
    for (int i = 0; i < 9; i++)
      check("stall_word", 32'(got_at(i)), 32'({17'(i), 16'(12'h100 + i)}));

    // Pixels outside any frame, then clear_ovf racing a drop.
    do_reset();
    drive(1'b0, 2'd0, 1'b1, 12'h055, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 12'h056, 1'b0);
    idle(8);
    check("nofrm_starts", 32'(n_starts), 32'd0);
    check("nofrm_overflow", 32'(overflow), 32'd1);
    check("nofrm_drop_count", 32'(drop_count), 32'd2);
    drive(1'b0, 2'd0, 1'b1, 12'h0AA, 1'b1);
    check("clr_drop_overflow", 32'(overflow), 32'd1);
    check("clr_drop_count", 32'(drop_count), 32'd1);
    drive(1'b0, 2'd0, 1'b0, 12'h000, 1'b1);
    check("clr_overflow", 32'(overflow), 32'd0);
    check("clr_count", 32'(drop_count), 32'd0);

    // frame_start mid-frame: queued words keep their bank-0 addresses.
    do_reset();
    drive(1'b1, 2'd0, 1'b1, 12'h301, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 12'h302, 1'b0);
    drive(1'b1, 2'd1, 1'b1, 12'h303, 1'b0);
    idle(25);
    check("abandon_writes", 32'(n_starts), 32'd3);
    check("abandon_w0", 32'(got_at(0)), 32'({17'h00000, 16'h0301}));
    check("abandon_w1", 32'(got_at(1)), 32'({17'h00001, 16'h0302}));
    check("abandon_w2", 32'(got_at(2)), 32'({17'h08000, 16'h0303}));
    check("abandon_frame_done", 32'(fd_count), 32'd0);

    // Asynchronous reset while a write waits for completion.
    do_reset();
    hold_low = 1'b1;
    drive(1'b1, 2'd3, 1'b1, 12'h401, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 12'h402, 1'b0);
    drive(1'b0, 2'd0, 1'b1, 12'h403, 1'b0);
    idle(4);
    check("arst_pre_starts", 32'(n_starts), 32'd1);
    #3 reset = 1'b0;
    #1;
    check("arst_sram_start", 32'(sram_start), 32'd1);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_frame_done", 32'(frame_done), 32'd0);
    @(negedge clk);
    hold_low = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    idle(30);
    check("arst_post_starts", 32'(n_starts), 32'd1);
    check("arst_post_frame_done", 32'(fd_count), 32'd0);

    // Randomized traffic against the reference model.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      busy_cycles = $urandom_range(2, 4);
      m_busy = busy_cycles;
      model_on = 1'b1;
      for (int c = 0; c < 400; c++)
        drive($urandom_range(0, 99) < 4, 2'($urandom_range(0, 3)), $urandom_range(0, 99) < 65,
              12'($urandom), $urandom_range(0, 99) < 3);
      idle(80);
      model_on = 1'b0;
      check("rnd_write_count", 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
        check("rnd_word", 32'(got_at(i) >> 1), 32'(exp_q[i] >> 1));
      check("rnd_frame_done", 32'(fd_count), 32'(exp_fd));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
